seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
- Sequences the 3-digit dynamic 7-segment display and shares it between two 8-bit requesters, A and B (e.g. PC and accumulator).
- Divides the clock into a refresh tick and runs a 6-slot frame: blank, ones, blank, tens, blank, hundreds.
- Converts the granted 8-bit binary value to BCD sequentially, one shift per cycle (double-dabble).
- Drives digit select and the BCD nibble into the existing dec7seg decoder, with leading-zero blanking.

Parameters:
DIV, 1000, clock cycles per display slot; legal range 2 to 65535.
HOLD, 64, frames a source keeps the display while the other source is also requesting; legal range 1 to 255.

Ports:
clock  in  1  system clock
Reset  in  1  synchronous reset, active-high
reqA  in  1  requester A wants the display (level)
srcA  in  8  requester A binary value
reqB  in  1  requester B wants the display (level)
srcB  in  8  requester B binary value
S  out  3  one-hot digit select: 001 ones, 010 tens, 100 hundreds, 000 all off
digit  out  4  BCD nibble to dec7seg; 0 whenever S=000
blank  out  1  1 whenever S=000
grantA  out  1  displayed data belongs to A
grantB  out  1  displayed data belongs to B
busy  out  1  conversion in progress

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset has priority over all other activity, including a conversion in progress.
- Reset values:
  - prescaler=0, slot=0, frame counter=0, conversion FSM=IDLE.
  - BCD buffer=000 (3 nibbles), grant=NONE.
  - Outputs: S=000, digit=0, blank=1, grantA=0, grantB=0, busy=0.
- Prescaler counts 0..DIV-1. tick=1 for one cycle when prescaler==DIV-1, then prescaler wraps to 0.
- Slot counter 0..5 advances on tick and wraps 5->0. frame_end = tick while slot==5.
- Arbitration at frame_end computes next grant N; cur is the committed grant.
  - Neither req -> N=NONE.
  - Only one req -> N=that source.
  - Both req, cur=NONE -> N=A (A wins ties).
  - Both req, cur=A or B -> switch to the other source when frame counter==HOLD-1, else keep cur.
  - Frame counter counts frame_ends while N==cur. It clears to 0 when N!=cur or on reaching HOLD-1.
  - A req dropping mid-frame has no effect until the next frame_end.
- Conversion FSM: IDLE -> CONV -> COMMIT -> IDLE.
  - At frame_end with N!=NONE: latch value (srcA or srcB per N) and pending grant N; clear the 12-bit shift register; enter CONV; busy=1.
  - CONV, exactly 8 cycles: each cycle add 3 to every BCD nibble >=5, then shift left 1, taking the value MSB in.
  - COMMIT, 1 cycle: BCD buffer <= result; grant <= pending; busy=0 next cycle.
  - Total 9 cycles from frame_end to the visible update. Because DIV>=2, a conversion always finishes before the next frame_end.
  - At frame_end with N=NONE: grant <= NONE immediately. BCD buffer is retained, not displayed.
- Source values are sampled only at frame_end. Changes within a frame are invisible until the next commit.
- Display decode is combinational from the registered slot, buffer and grant. It tracks slot changes in the same cycle.
  - Even slot, or grant=NONE -> S=000.
  - Slot 1 -> S=001, ones nibble.
  - Slot 3 -> S=010, tens nibble.
  - Slot 5 -> S=100, hundreds nibble.
  - Leading-zero suppression:
    - Hundreds suppressed if it is 0.
    - Tens suppressed if hundreds and tens are both 0.
    - Ones is never suppressed.
    - A suppressed digit gives S=000, digit=0, blank=1.
- grantA/grantB reflect the committed grant only; they are never both 1.
- Arithmetic: value 0..255 gives BCD 000..255. The hundreds nibble is at most 2.

Test Plan (DIV=4, HOLD=2):
1. Reset held 3 cycles, no requests, run 100 cycles -> S=000, blank=1, digit=0, grantA=grantB=0, busy=0 throughout.
2. reqA=1, srcA=255 from reset release -> busy high cycles 24-31 after release; grantA=1 at cycle 33; slots 1/3/5 then show S=001/5, 010/5, 100/2.
3. reqA=1, srcA=7 -> only slot 1 shows S=001 with digit 7. Slots 3 and 5 give S=000, blank=1. srcA=100 -> digits 0,0,1 all displayed.
4. reqA=reqB=1, srcA=12, srcB=34 -> grant sequence A,A,B,B,A... across frames. Displayed digits alternate 2/1 and 4/3 every 2 frames.
5. Grant=A, reqA drops mid-frame, reqB=0 -> display persists to the frame end; at frame_end grant=NONE and S=000 from then on.
6. Reset asserted during CONV -> next cycle busy=0, all outputs at reset values, no commit occurs. srcA changed mid-frame -> old digits remain until 9 cycles after the next frame_end.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// Shares a 3-digit multiplexed 7-segment display between two 8-bit sources,
// converting the granted value to BCD with a sequential double-dabble.
module seg_display_scheduler #(
  parameter int DIV  = 1000,
  parameter int HOLD = 64
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       reqA,
  input  logic [7:0] srcA,
  input  logic       reqB,
  input  logic [7:0] srcB,
  output logic [2:0] S,
  output logic [3:0] digit,
  output logic       blank,
  output logic       grantA,
  output logic       grantB,
  output logic       busy
);

  typedef enum logic [1:0] {G_NONE, G_A, G_B} grant_t;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [15:0] PMAX = 16'(DIV - 1);
  localparam logic [7:0]  FMAX = 8'(HOLD - 1);

  logic [15:0] presc;
  logic [2:0]  slot;
  logic [7:0]  fcnt;
  logic [7:0]  val;
  logic [2:0]  bcnt;
  logic [11:0] sh;
  logic [11:0] bcd_q;
  grant_t      cur, pend, nxt;
  state_t      state, state_nxt;
  logic        tick, frame_end;
  logic [3:0]  t_a, o_a;

  assign tick      = (presc == PMAX);
  assign frame_end = tick && (slot == 3'd5);

  always_comb begin
    nxt = G_NONE;
    if (reqA && reqB) begin
      if (cur == G_NONE)     nxt = G_A;
      else if (fcnt == FMAX) nxt = (cur == G_A) ? G_B : G_A;
      else                   nxt = cur;
    end else if (reqA) begin
      nxt = G_A;
    end else if (reqB) begin
      nxt = G_B;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_end && nxt != G_NONE) state_nxt = CONV;
      CONV:    if (bcnt == 3'd7) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hundreds stays below 5 for 8-bit inputs, so it never needs the +3 fix.
  assign t_a = (sh[7:4] >= 4'd5) ? sh[7:4] + 4'd3 : sh[7:4];
  assign o_a = (sh[3:0] >= 4'd5) ? sh[3:0] + 4'd3 : sh[3:0];

  always_ff @(posedge clock) begin
    if (Reset) begin
      presc <= '0;
      slot  <= '0;
      fcnt  <= '0;
      val   <= '0;
      bcnt  <= '0;
      sh    <= '0;
      bcd_q <= '0;
      cur   <= G_NONE;
      pend  <= G_NONE;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      if (frame_end) begin
        fcnt <= (nxt != cur || fcnt == FMAX) ? 8'd0 : fcnt + 8'd1;
        if (nxt == G_NONE) begin
          cur <= G_NONE;
        end else begin
          val  <= (nxt == G_A) ? srcA : srcB;
          pend <= nxt;
          sh   <= '0;
          bcnt <= '0;
        end
      end
      if (state == CONV) begin
        sh   <= {sh[10:8], t_a, o_a, val[7]};
        val  <= {val[6:0], 1'b0};
        bcnt <= bcnt + 3'd1;
      end
      if (state == COMMIT) begin
        bcd_q <= sh;
        cur   <= pend;
      end
    end
  end

  always_comb begin
    S     = 3'b000;
    digit = 4'd0;
    if (cur != G_NONE) begin
      if (slot == 3'd1) begin
        S     = 3'b001;
        digit = bcd_q[3:0];
      end else if (slot == 3'd3 && bcd_q[11:4] != 8'd0) begin
        S     = 3'b010;
        digit = bcd_q[7:4];
      end else if (slot == 3'd5 && bcd_q[11:8] != 4'd0) begin
        S     = 3'b100;
        digit = bcd_q[11:8];
      end
    end
  end

  assign blank  = (S == 3'b000);
  assign grantA = (cur == G_A);
  assign grantB = (cur == G_B);
  assign busy   = (state == CONV);

endmodule
